// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported delay-1 RAM between the
// instruction-fetch port and the data port (data favoured).
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [DATA_W-1:0] i_readdata,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_D = 2'd1,
        RD_I = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state;
    logic [3:0] d_streak;
    logic       d_req;
    logic       i_win;
    logic       d_win;

    // a simultaneous read+write is handled as a write
    assign d_req = d_read | d_write;
    assign i_win = i_read & (~d_req | (d_streak == STREAK_MAX));
    assign d_win = ~i_win & d_req;

    assign i_readdata = ram_readdata;
    assign d_readdata = ram_readdata;

    // RAM drive and completion handshakes for the current state
    always_comb begin
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        ram_address   = '0;
        ram_writedata = '0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (i_win) begin
                        ram_read    = 1'b1;
                        ram_address = i_address;
                    end else if (d_win) begin
                        ram_address = d_address;
                        if (d_write) begin
                            ram_write     = 1'b1;
                            ram_writedata = d_writedata;
                            d_waitrequest = 1'b0;
                        end else begin
                            ram_read = 1'b1;
                        end
                    end
                end
                RD_D:    d_waitrequest = 1'b0;
                RD_I:    i_waitrequest = 1'b0;
                default: ;
            endcase
        end
    end

    // state sequencing and fetch starvation guard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            d_streak <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_win) begin
                        state <= RD_I;
                    end else if (d_win && !d_write) begin
                        state <= RD_D;
                    end
                end
                RD_D:    state <= IDLE;
                RD_I:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!i_read) begin
                d_streak <= '0;
            end else if (state == IDLE) begin
                if (i_win) begin
                    d_streak <= '0;
                end else if (d_win && d_streak != STREAK_MAX) begin
                    d_streak <= d_streak + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a delay-1 RAM model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_D_STREAK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_address(i_address),
        .i_read(i_read),
        .i_waitrequest(i_waitrequest),
        .i_readdata(i_readdata),
        .d_address(d_address),
        .d_read(d_read),
        .d_write(d_write),
        .d_writedata(d_writedata),
        .d_waitrequest(d_waitrequest),
        .d_readdata(d_readdata),
        .ram_address(ram_address),
        .ram_read(ram_read),
        .ram_write(ram_write),
        .ram_writedata(ram_writedata),
        .ram_readdata(ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // delay-1 RAM; the two fetch words are reloaded while in reset
    always @(posedge clk) begin
        if (reset) begin
            mem[0] <= 32'h24020005;
            mem[1] <= 32'h8C430004;
        end else begin
            if (ram_write) mem[ram_address[7:2]] <= ram_writedata;
            if (ram_read) ram_readdata <= mem[ram_address[7:2]];
        end
    end

    always @(negedge clk) begin
        if (!reset && d_read && d_write)
            $display("note: d_read and d_write both high at %0t", $time);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic        e_iw;
        logic        e_dw;
        logic        e_rr;
        logic        e_rw;
        logic [31:0] e_ra;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // ir dr dw ia da wd | iwait dwait rr rw addr wdata
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'hBFC00040, 32'h11112222,
                    1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC00040, 32'h11112222};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hBFC00044, 32'h0,
                    1'b1, 1'b1, 1'b1, 1'b0, 32'hBFC00044, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hBFC00008, 32'h0, 32'h0,
                    1'b1, 1'b1, 1'b1, 1'b0, 32'hBFC00008, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hBFC00008, 32'hBFC00048, 32'h0,
                    1'b1, 1'b1, 1'b1, 1'b0, 32'hBFC00048, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'hBFC00008, 32'hBFC0004C, 32'h5A5A,
                    1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0004C, 32'h5A5A};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'hBFC00050, 32'h77,
                    1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC00050, 32'h77};

        reset = 1'b1;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0;
        repeat (3) @(posedge clk);

        // single-cycle decode from IDLE; reset reasserted before the edge
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            i_read = vecs[i].ir; d_read = vecs[i].dr; d_write = vecs[i].dw;
            i_address = vecs[i].ia; d_address = vecs[i].da;
            d_writedata = vecs[i].wd;
            #2;
            chk($sformatf("vec%0d_iwait", i), 64'(i_waitrequest), 64'(vecs[i].e_iw));
            chk($sformatf("vec%0d_dwait", i), 64'(d_waitrequest), 64'(vecs[i].e_dw));
            chk($sformatf("vec%0d_ramrd", i), 64'(ram_read), 64'(vecs[i].e_rr));
            chk($sformatf("vec%0d_ramwr", i), 64'(ram_write), 64'(vecs[i].e_rw));
            chk($sformatf("vec%0d_addr", i), 64'(ram_address), 64'(vecs[i].e_ra));
            chk($sformatf("vec%0d_wdata", i), 64'(ram_writedata), 64'(vecs[i].e_wd));
            reset = 1'b1;
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end

        // fetch, then async reset in the RD_I cycle, then re-issue
        @(posedge clk); #1;
        reset = 1'b0; i_read = 1'b1; i_address = 32'hBFC00000;
        #2 chk("rst_idle_ramrd", 64'(ram_read), 64'd1);
        @(posedge clk); #3;
        chk("rdi_iwait_pre", 64'(i_waitrequest), 64'd0);
        reset = 1'b1;
        #1;
        chk("rst_iwait", 64'(i_waitrequest), 64'd1);
        chk("rst_dwait", 64'(d_waitrequest), 64'd1);
        chk("rst_ramrd", 64'(ram_read), 64'd0);
        chk("rst_ramwr", 64'(ram_write), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        chk("refetch_c0_ramrd", 64'(ram_read), 64'd1);
        chk("refetch_c0_iwait", 64'(i_waitrequest), 64'd1);
        chk("refetch_c0_addr", 64'(ram_address), 64'hBFC00000);
        @(posedge clk); #2;
        chk("refetch_c1_iwait", 64'(i_waitrequest), 64'd0);
        chk("refetch_c1_data", 64'(i_readdata), 64'h24020005);
        @(posedge clk); #1;
        i_read = 1'b0;

        // fetch only
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 32'hBFC00000;
        #2;
        chk("fetch_c0_iwait", 64'(i_waitrequest), 64'd1);
        chk("fetch_c0_ramrd", 64'(ram_read), 64'd1);
        @(posedge clk); #2;
        chk("fetch_c1_iwait", 64'(i_waitrequest), 64'd0);
        chk("fetch_c1_ramrd", 64'(ram_read), 64'd0);
        chk("fetch_c1_data", 64'(i_readdata), 64'h24020005);
        @(posedge clk); #1;
        i_read = 1'b0;

        // data write then read back
        @(posedge clk); #1;
        d_write = 1'b1; d_address = 32'hBFC00010; d_writedata = 32'hDEADBEEF;
        #2;
        chk("wr_c0_dwait", 64'(d_waitrequest), 64'd0);
        chk("wr_c0_ramwr", 64'(ram_write), 64'd1);
        @(posedge clk); #1;
        d_write = 1'b0; d_read = 1'b1;
        #2;
        chk("rd_c0_dwait", 64'(d_waitrequest), 64'd1);
        chk("rd_c0_ramrd", 64'(ram_read), 64'd1);
        @(posedge clk); #2;
        chk("rd_c1_dwait", 64'(d_waitrequest), 64'd0);
        chk("rd_c1_data", 64'(d_readdata), 64'hDEADBEEF);
        @(posedge clk); #1;
        d_read = 1'b0;

        // contention: data first, fetch second
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 32'hBFC00000;
        d_read = 1'b1; d_address = 32'hBFC00004;
        #2;
        chk("ct_c0_addr", 64'(ram_address), 64'hBFC00004);
        chk("ct_c0_iwait", 64'(i_waitrequest), 64'd1);
        @(posedge clk); #2;
        chk("ct_c1_dwait", 64'(d_waitrequest), 64'd0);
        chk("ct_c1_ddata", 64'(d_readdata), 64'h8C430004);
        chk("ct_c1_iwait", 64'(i_waitrequest), 64'd1);
        @(posedge clk); #1;
        d_read = 1'b0;
        #2;
        chk("ct_c2_iwait", 64'(i_waitrequest), 64'd1);
        chk("ct_c2_addr", 64'(ram_address), 64'hBFC00000);
        @(posedge clk); #2;
        chk("ct_c3_iwait", 64'(i_waitrequest), 64'd0);
        chk("ct_c3_idata", 64'(i_readdata), 64'h24020005);
        @(posedge clk); #1;
        i_read = 1'b0;

        // starvation guard: 4 writes, forced fetch, writes resume
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 32'hBFC00000; d_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_address = 32'hBFC00020 + 32'(k * 4);
            d_writedata = 32'(k + 1);
            #2;
            chk($sformatf("sv_w%0d_dwait", k), 64'(d_waitrequest), 64'd0);
            chk($sformatf("sv_w%0d_ramwr", k), 64'(ram_write), 64'd1);
            chk($sformatf("sv_w%0d_iwait", k), 64'(i_waitrequest), 64'd1);
            @(posedge clk); #1;
        end
        #2;
        chk("sv_c4_streak", 64'(dut.d_streak), 64'd4);
        chk("sv_c4_ramrd", 64'(ram_read), 64'd1);
        chk("sv_c4_ramwr", 64'(ram_write), 64'd0);
        chk("sv_c4_addr", 64'(ram_address), 64'hBFC00000);
        chk("sv_c4_dwait", 64'(d_waitrequest), 64'd1);
        @(posedge clk); #2;
        chk("sv_c5_iwait", 64'(i_waitrequest), 64'd0);
        chk("sv_c5_idata", 64'(i_readdata), 64'h24020005);
        chk("sv_c5_dwait", 64'(d_waitrequest), 64'd1);
        @(posedge clk); #1;
        i_read = 1'b0; d_address = 32'hBFC00030; d_writedata = 32'h5;
        #2;
        chk("sv_c6_dwait", 64'(d_waitrequest), 64'd0);
        chk("sv_c6_ramwr", 64'(ram_write), 64'd1);
        chk("sv_c6_streak", 64'(dut.d_streak), 64'd0);
        @(posedge clk); #1;
        d_write = 1'b0; d_read = 1'b1; d_address = 32'hBFC0002C;
        @(posedge clk); #2;
        chk("sv_rb_data", 64'(d_readdata), 64'd4);
        @(posedge clk); #1;
        d_read = 1'b0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
